mlp_layer_sequencer: RTL and testbench

- Parametrised address/control sequencer for the MLP datapath. Walks every (layer, output neuron, input weight) triple of a runtime-programmable topology.
- Drives neuron-RAM read/write addresses, weight-ROM address and multiply-accumulate control.
- Adds over the fixed 4-2-2-1 sequencer: programmable layer-size table, start/busy/done handshake, memory stall, abort, and a config-error check.
- Sits between the top-level controller and the neuron RAM / weight ROM / MAC; done hands off to softmax.

---
 rtl/mlp_layer_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer
//   Address/control sequencer for the MLP datapath. Walks every
//   (layer, output neuron, input weight) triple of a topology held in a
//   small runtime-programmable layer-size table, driving neuron-RAM read
//   and write addresses, the weight-ROM address and MAC control.
//
// Ports
//   clk, reset             clock, asynchronous active-low reset
//   cfg_we/cfg_layer/      table write (IDLE only)
//     cfg_count
//   cfg_num_we/cfg_num     layer-count write (IDLE only)
//   start, abort           run request / synchronous abort
//   mem_ready              0 stalls the walk (counters hold, no MAC beat)
//   busy, done, cfg_err    status: running, run finished, start rejected
//   input_neuron_addr      {layer, weight_idx}
//   output_neuron_addr     {layer+1, neuron_idx}
//   weight_addr            {layer, neuron_idx, weight_idx}
//   mac_en, mac_first      accumulate strobe, first beat of a neuron
//   write_neuron           store accumulator at output_neuron_addr
//   last_layer             current output layer is the final one
module mlp_layer_sequencer #(
    parameter int                 MAX_LAYERS     = 8,
    parameter int                 LAYER_W        = 3,
    parameter int                 IDX_W          = 8,
    parameter logic [4*IDX_W-1:0] DEF_TOPO       = {8'd4, 8'd2, 8'd2, 8'd1},
    parameter int                 DEF_NUM_LAYERS = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [LAYER_W-1:0]         cfg_layer,
    input  logic [IDX_W-1:0]           cfg_count,
    input  logic                       cfg_num_we,
    input  logic [LAYER_W:0]           cfg_num,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       mem_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       cfg_err,
    output logic [LAYER_W+IDX_W-1:0]   input_neuron_addr,
    output logic [LAYER_W+IDX_W-1:0]   output_neuron_addr,
    output logic [LAYER_W+2*IDX_W-1:0] weight_addr,
    output logic                       mac_en,
    output logic                       mac_first,
    output logic                       write_neuron,
    output logic                       last_layer
);

    localparam int NA_W = LAYER_W + IDX_W;
    localparam int WA_W = LAYER_W + 2 * IDX_W;
    localparam logic [LAYER_W:0] MAX_L = (LAYER_W + 1)'(MAX_LAYERS);
    localparam logic [LAYER_W:0] TWO_L = (LAYER_W + 1)'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Reset contents of table entry i: entry 0 sits in the top slice of DEF_TOPO.
    function automatic logic [IDX_W-1:0] def_entry(input int i);
        if (i < 4) return DEF_TOPO[(3 - i) * IDX_W +: IDX_W];
        return '0;
    endfunction

    state_t               state_q, state_d;
    logic [LAYER_W-1:0]   lay_q, lay_d;
    logic [IDX_W-1:0]     nrn_q, nrn_d;
    logic [IDX_W-1:0]     wgt_q, wgt_d;
    logic [IDX_W-1:0]     tbl_q [MAX_LAYERS];
    logic [IDX_W-1:0]     tbl_d [MAX_LAYERS];
    logic [LAYER_W:0]     num_q, num_d;
    logic                 wr_pend_q, wr_pend_d;
    logic [NA_W-1:0]      pend_addr_q, pend_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [NA_W-1:0]      in_addr_q, in_addr_d;
    logic [NA_W-1:0]      out_addr_q, out_addr_d;
    logic [WA_W-1:0]      w_addr_q, w_addr_d;
    logic                 mac_en_q, mac_en_d;
    logic                 mac_first_q, mac_first_d;
    logic                 write_neuron_q, write_neuron_d;
    logic                 last_layer_q, last_layer_d;

    // Walk helpers for the current (L, N, W).
    logic [LAYER_W-1:0] lay_p1;
    logic [LAYER_W:0]   lay_p2;
    logic [IDX_W-1:0]   in_cnt, out_cnt;
    logic               is_last_lay, last_w, last_n, cfg_ok;

    always_comb begin
        lay_p1      = lay_q + 1'b1;
        lay_p2      = {1'b0, lay_q} + TWO_L;
        in_cnt      = tbl_q[lay_q];
        out_cnt     = tbl_q[lay_p1];
        is_last_lay = (lay_p2 == num_q);
        last_w      = (wgt_q == in_cnt - IDX_W'(1));
        last_n      = (nrn_q == out_cnt - IDX_W'(1));
    end

    // Start is accepted only for a topology the walk can terminate on.
    always_comb begin
        cfg_ok = (num_q >= TWO_L) && (num_q <= MAX_L);
        for (int i = 0; i < MAX_LAYERS; i++) begin
            if ((i < int'(num_q)) && (tbl_q[i] == '0)) cfg_ok = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        lay_d          = lay_q;
        nrn_d          = nrn_q;
        wgt_d          = wgt_q;
        tbl_d          = tbl_q;
        num_d          = num_q;
        wr_pend_d      = 1'b0;
        pend_addr_d    = pend_addr_q;
        write_neuron_d = wr_pend_q;   // write follows the last beat regardless of mem_ready
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;
        mac_en_d       = 1'b0;
        mac_first_d    = 1'b0;
        in_addr_d      = in_addr_q;
        out_addr_d     = out_addr_q;
        w_addr_d       = w_addr_q;
        last_layer_d   = last_layer_q;

        case (state_q)
            S_IDLE: begin
                if (cfg_we && (int'(cfg_layer) < MAX_LAYERS)) tbl_d[cfg_layer] = cfg_count;
                if (cfg_num_we) num_d = cfg_num;
                if (start && !abort) begin
                    if (cfg_ok) begin
                        state_d = S_RUN;
                        lay_d   = '0;
                        nrn_d   = '0;
                        wgt_d   = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d        = S_IDLE;
                    write_neuron_d = 1'b0;
                end else if (mem_ready) begin
                    mac_en_d     = 1'b1;
                    mac_first_d  = (wgt_q == '0);
                    in_addr_d    = {lay_q, wgt_q};
                    w_addr_d     = {lay_q, nrn_q, wgt_q};
                    last_layer_d = is_last_lay;
                    if (!last_w) begin
                        wgt_d = wgt_q + 1'b1;
                    end else begin
                        wgt_d       = '0;
                        wr_pend_d   = 1'b1;
                        pend_addr_d = {lay_p1, nrn_q};
                        out_addr_d  = {lay_p1, nrn_q};
                        if (!last_n) begin
                            nrn_d = nrn_q + 1'b1;
                        end else if (!is_last_lay) begin
                            nrn_d = '0;
                            lay_d = lay_p1;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d        = S_IDLE;
                    write_neuron_d = 1'b0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A write issuing now owns output_neuron_addr; with single-weight
        // neurons the next last beat lands on this same edge and must wait.
        if (write_neuron_d) out_addr_d = pend_addr_q;

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            lay_q          <= '0;
            nrn_q          <= '0;
            wgt_q          <= '0;
            for (int i = 0; i < MAX_LAYERS; i++) tbl_q[i] <= def_entry(i);
            num_q          <= (LAYER_W + 1)'(DEF_NUM_LAYERS);
            wr_pend_q      <= 1'b0;
            pend_addr_q    <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            in_addr_q      <= '0;
            out_addr_q     <= '0;
            w_addr_q       <= '0;
            mac_en_q       <= 1'b0;
            mac_first_q    <= 1'b0;
            write_neuron_q <= 1'b0;
            last_layer_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            lay_q          <= lay_d;
            nrn_q          <= nrn_d;
            wgt_q          <= wgt_d;
            tbl_q          <= tbl_d;
            num_q          <= num_d;
            wr_pend_q      <= wr_pend_d;
            pend_addr_q    <= pend_addr_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
            in_addr_q      <= in_addr_d;
            out_addr_q     <= out_addr_d;
            w_addr_q       <= w_addr_d;
            mac_en_q       <= mac_en_d;
            mac_first_q    <= mac_first_d;
            write_neuron_q <= write_neuron_d;
            last_layer_q   <= last_layer_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign cfg_err            = cfg_err_q;
    assign input_neuron_addr  = in_addr_q;
    assign output_neuron_addr = out_addr_q;
    assign weight_addr        = w_addr_q;
    assign mac_en             = mac_en_q;
    assign mac_first          = mac_first_q;
    assign write_neuron       = write_neuron_q;
    assign last_layer         = last_layer_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Testbench for mlp_layer_sequencer: table of topology vectors run through a
// reference walk, plus hand sequences for abort, async reset, start+abort and
// config writes while busy.
module tb_mlp_layer_sequencer;

    localparam int LW = 3;
    localparam int IW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cfg_we = 1'b0;
    logic [LW-1:0]     cfg_layer = '0;
    logic [IW-1:0]     cfg_count = '0;
    logic              cfg_num_we = 1'b0;
    logic [LW:0]       cfg_num = '0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              mem_ready = 1'b1;
    logic              busy, done, cfg_err;
    logic [LW+IW-1:0]  input_neuron_addr, output_neuron_addr;
    logic [LW+2*IW-1:0] weight_addr;
    logic              mac_en, mac_first, write_neuron, last_layer;

    mlp_layer_sequencer dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_count(cfg_count),
        .cfg_num_we(cfg_num_we), .cfg_num(cfg_num),
        .start(start), .abort(abort), .mem_ready(mem_ready),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .input_neuron_addr(input_neuron_addr), .output_neuron_addr(output_neuron_addr),
        .weight_addr(weight_addr), .mac_en(mac_en), .mac_first(mac_first),
        .write_neuron(write_neuron), .last_layer(last_layer)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        int    num;
        int    t0, t1, t2, t3;
        bit    toggle;
        bit    exp_err;
        int    exp_beats;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input vec_t v);
        int tt [4];
        tt = '{v.t0, v.t1, v.t2, v.t3};
        for (int i = 0; i < 4; i++) begin
            cfg_we    = 1'b1;
            cfg_layer = LW'(i);
            cfg_count = IW'(tt[i]);
            tick();
        end
        cfg_we     = 1'b0;
        cfg_num_we = 1'b1;
        cfg_num    = (LW + 1)'(v.num);
        tick();
        cfg_num_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input bit busy_cfg);
        int tt [4];
        logic [LW+2*IW-1:0] exp_w [$];
        logic [LW+IW-1:0]   exp_i [$];
        logic [LW+IW-1:0]   exp_o [$];
        bit                 exp_f [$];
        int  bi, wi, cyc, last_wr, bad;
        bit  seen_done;
        tt = '{v.t0, v.t1, v.t2, v.t3};
        if (!v.exp_err) begin
            for (int l = 0; l < v.num - 1; l++)
                for (int n = 0; n < tt[l+1]; n++) begin
                    for (int w = 0; w < tt[l]; w++) begin
                        exp_w.push_back({LW'(l), IW'(n), IW'(w)});
                        exp_i.push_back({LW'(l), IW'(w)});
                        exp_f.push_back(w == 0);
                    end
                    exp_o.push_back({LW'(l + 1), IW'(n)});
                end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        if (v.exp_err) begin
            chk({v.name, " cfg_err_pulse"}, cfg_err, 1);
            chk({v.name, " busy_on_err"}, busy, 0);
            bad = 0;
            for (int k = 0; k < 6; k++) begin
                tick();
                if (cfg_err || busy || mac_en || write_neuron || done) bad++;
            end
            chk({v.name, " quiet_after_err"}, bad, 0);
            return;
        end
        chk({v.name, " busy_rise"}, busy, 1);
        bi = 0; wi = 0; cyc = 0; last_wr = -10; seen_done = 0;
        while (!seen_done && cyc < 3000) begin
            mem_ready = v.toggle ? ~cyc[0] : 1'b1;
            cfg_we    = busy_cfg & busy;
            cfg_layer = LW'(1);
            cfg_count = IW'(7);
            tick();
            cyc++;
            if (mac_en) begin
                if (bi < exp_w.size()) begin
                    chk({v.name, " weight_addr"}, weight_addr, exp_w[bi]);
                    chk({v.name, " input_addr"}, input_neuron_addr, exp_i[bi]);
                    chk({v.name, " mac_first"}, mac_first, exp_f[bi]);
                end else begin
                    chk({v.name, " extra_beat"}, 1, 0);
                end
                bi++;
            end else if (bi > 0 && bi <= exp_w.size()) begin
                chk({v.name, " stall_hold"}, weight_addr, exp_w[bi-1]);
                chk({v.name, " stall_first"}, mac_first, 0);
            end
            if (write_neuron) begin
                if (wi < exp_o.size()) chk({v.name, " write_addr"}, output_neuron_addr, exp_o[wi]);
                else chk({v.name, " extra_write"}, 1, 0);
                chk({v.name, " write_vs_done"}, done, 0);
                wi++;
                last_wr = cyc;
            end
            if (done) begin
                seen_done = 1;
                chk({v.name, " done_gap"}, cyc - last_wr, 1);
                chk({v.name, " busy_at_done"}, busy, 0);
            end
        end
        cfg_we    = 1'b0;
        mem_ready = 1'b1;
        chk({v.name, " done_seen"}, seen_done, 1);
        chk({v.name, " beats"}, bi, v.exp_beats);
        chk({v.name, " writes"}, wi, exp_o.size());
        tick();
        chk({v.name, " done_one_cycle"}, done, 0);
    endtask

    initial begin
        int n, bad;

        vecs[0] = '{"default_4221", 4, 4, 2, 2, 1, 1'b0, 1'b0, 14};
        vecs[1] = '{"stall_352",    3, 3, 5, 2, 0, 1'b1, 1'b0, 25};
        vecs[2] = '{"zero_entry",   4, 4, 2, 0, 1, 1'b0, 1'b1, 0};
        vecs[3] = '{"one_layer",    1, 4, 2, 2, 1, 1'b0, 1'b1, 0};
        vecs[4] = '{"single_wgt",   3, 1, 3, 1, 0, 1'b0, 1'b0, 6};
        vecs[5] = '{"two_layer",    2, 2, 3, 0, 0, 1'b1, 1'b0, 6};

        // Reset state
        #12;
        chk("rst_strobes", {busy, done, cfg_err, mac_en, mac_first, write_neuron, last_layer}, 0);
        chk("rst_addrs", {input_neuron_addr, output_neuron_addr}, 0);
        chk("rst_waddr", weight_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Vector table: vector 0 uses the reset topology as-is
        for (int i = 0; i < 6; i++) begin
            if (i > 0) configure(vecs[i]);
            run_vec(vecs[i], 1'b0);
        end

        // Abort on beat 6 of the default run, then a clean rerun
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 6; k++) begin
            tick();
            if (mac_en) n++;
        end
        chk("abort_beat6_addr", weight_addr, {3'd0, 8'd1, 8'd1});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", {busy, mac_en, write_neuron, done}, 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done || write_neuron || mac_en || busy) bad++;
        end
        chk("abort_quiet", bad, 0);
        run_vec(vecs[0], 1'b0);

        // start and abort together in IDLE: no transition
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", {busy, cfg_err}, 0);
        tick();
        chk("start_abort_no_beat", mac_en, 0);

        // Asynchronous reset mid-run of a non-default topology
        configure(vecs[1]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_strobes", {busy, done, cfg_err, mac_en, mac_first, write_neuron, last_layer}, 0);
        chk("async_rst_addrs", {input_neuron_addr, output_neuron_addr}, 0);
        chk("async_rst_waddr", weight_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_vec(vecs[0], 1'b0);

        // cfg writes of table[1]=7 while busy must be dropped
        run_vec(vecs[0], 1'b1);
        run_vec(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
